fir_seq_ctrl: RTL
=================

Name: fir_seq_ctrl

Overview:
- Sequencer for a time-multiplexed single-MAC FIR datapath: circular sample RAM of N words, coefficient ROM of N words, one accumulator.
- On each input sample strobe, writes the new sample, steps the MAC through all N taps, then loads the output register and pulses output_ready.
- Zero-fills the sample RAM after reset.
- Flags strobes that arrive while a computation is in progress.

Parameters:
- N, 31, number of taps; N >= 2.
- AW, $clog2(N), width of every RAM/ROM address port.

Ports:
- ck  in  1  system clock; all activity on rising edge.
- rst  in  1  synchronous active-low reset.
- input_ready  in  1  sample strobe from the sample-rate generator; level of any length; rising edge starts one computation.
- clr_ovr  in  1  clears the sticky overrun flag.
- sample_we  out  1  sample RAM write enable.
- zero_fill  out  1  selects 0 instead of the input sample as RAM write data.
- sample_waddr  out  AW  sample RAM write address.
- sample_raddr  out  AW  sample RAM read address (combinational read in datapath).
- coef_addr  out  AW  coefficient ROM address.
- acc_clr  out  1  clears the accumulator.
- acc_en  out  1  accumulate sample*coef this cycle.
- out_load  out  1  loads the accumulator into the output register.
- output_ready  out  1  one-cycle pulse; output valid.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; a strobe was dropped.

Behaviour:
- Reset (rst==0 at a clock edge):
  - state=INIT; wptr=0; k=0; in_prev=0; overrun=0.
  - All outputs are registered and all are 0, except busy=1.
  - Reset mid-computation aborts it; no output_ready is produced.
- Edge detect:
  - edge = input_ready & ~in_prev; in_prev is registered every cycle.
  - input_ready already high on the first cycle after reset counts as an edge.
- INIT, N cycles, i=0..N-1:
  - sample_we=1, zero_fill=1, sample_waddr=i.
  - After i=N-1, go to IDLE.
- IDLE:
  - busy=0.
  - On edge, go to WRITE next cycle.
- WRITE, 1 cycle:
  - sample_we=1, zero_fill=0, sample_waddr=wptr, acc_clr=1.
  - Then go to MAC with k=0.
- MAC, N cycles, k=0..N-1:
  - acc_en=1, coef_addr=k, sample_raddr=(wptr-k) mod N, wrapping N-1 -> 0 with no out-of-range address.
  - After k=N-1, go to DONE.
- DONE, 1 cycle:
  - out_load=1, output_ready=1.
  - wptr <= (wptr==N-1) ? 0 : wptr+1.
  - Then go to IDLE.
- Latency:
  - Edge sampled in cycle E: WRITE in E+1, MAC in E+2..E+N+1, DONE/output_ready in E+N+2.
  - Minimum strobe period is N+3 cycles.
- Overrun:
  - Any edge detected in a state other than IDLE (including INIT and DONE) is dropped and sets overrun.
  - The computation in progress is not disturbed.
  - clr_ovr clears overrun; set wins if both occur in the same cycle.
- Strobe held high: a level held high does not retrigger; a new computation needs a low cycle then a high cycle.
- Address widths: all addresses are AW bits; values are always in 0..N-1.

Test Plan:
- Reset release, input_ready=0 → busy=1 for 31 cycles with sample_waddr 0..30, sample_we=1, zero_fill=1; IDLE (busy=0) at cycle 31.
- Single strobe in IDLE, wptr=0 (edge sampled in cycle E) → WRITE at E+1, waddr=0, acc_clr=1; MAC cycles have coef_addr 0..30 and raddr 0,30,29,...,1; output_ready at E+33 only; wptr becomes 1.
- 32 strobes with a 40-cycle period → output_ready 32 times, never overrun; wptr wraps 30 -> 0; on the 32nd strobe waddr=0 and the MAC raddr sequence is 0,30,...,1.
- Strobes with a 25-cycle period (one-cycle-high pulse) → every other strobe dropped, overrun=1 after the second strobe, output_ready every 50 cycles; clr_ovr pulse → overrun=0, set again by the next dropped strobe.
- input_ready held high for 100 cycles → exactly one computation; it also behaves correctly when input_ready is high at reset release (counted as an edge during INIT → overrun=1, no computation).
- rst=0 asserted during the MAC at k=10 → next cycle all outputs 0, busy=1, state INIT from waddr 0, no output_ready, wptr=0, overrun=0.

Source files
------------

// File: rtl/fir_seq_ctrl_if.sv
// rtl/fir_seq_ctrl_if.sv - control bundle between the FIR sequencer and its MAC datapath
//
// Purpose : groups the strobe inputs and the RAM/ROM/accumulator controls.
// Signals : input_ready, clr_ovr            (datapath side -> sequencer)
//           sample_we, zero_fill, sample_waddr, sample_raddr, coef_addr,
//           acc_clr, acc_en, out_load, output_ready, busy, overrun
//                                            (sequencer -> datapath side)
// Modports: master = sequencer, slave = datapath / sample-rate generator.
interface fir_seq_ctrl_if #(
  parameter int AW = 5
);
  logic          input_ready;
  logic          clr_ovr;
  logic          sample_we;
  logic          zero_fill;
  logic [AW-1:0] sample_waddr;
  logic [AW-1:0] sample_raddr;
  logic [AW-1:0] coef_addr;
  logic          acc_clr;
  logic          acc_en;
  logic          out_load;
  logic          output_ready;
  logic          busy;
  logic          overrun;

  modport master (
    input  input_ready, clr_ovr,
    output sample_we, zero_fill, sample_waddr, sample_raddr, coef_addr,
           acc_clr, acc_en, out_load, output_ready, busy, overrun
  );

  modport slave (
    output input_ready, clr_ovr,
    input  sample_we, zero_fill, sample_waddr, sample_raddr, coef_addr,
           acc_clr, acc_en, out_load, output_ready, busy, overrun
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - sequencer for a time-multiplexed single-MAC FIR datapath
//
// Purpose : zero-fills the circular sample RAM after reset, then for every
//           rising edge of input_ready writes the sample, steps the MAC over
//           all N taps, loads the output register and pulses output_ready.
//           Strobes arriving outside IDLE are dropped and set sticky overrun.
// Ports   : ck   - clock, rising edge
//           rst  - synchronous active-low reset
//           bus  - fir_seq_ctrl_if.master (strobes in, datapath controls out)
module fir_seq_ctrl #(
  parameter int N  = 31,
  parameter int AW = $clog2(N)
) (
  input  logic           ck,
  input  logic           rst,
  fir_seq_ctrl_if.master bus
);
  // The counter must reach N during INIT, so it can be one bit wider than AW.
  localparam int CW = $clog2(N + 1);
  localparam int XW = CW + 1;
  localparam logic [CW-1:0] K_LAST = CW'(N - 1);
  localparam logic [CW-1:0] K_FILL = CW'(N);
  localparam logic [AW-1:0] W_LAST = AW'(N - 1);

  typedef enum logic [2:0] {INIT, IDLE, WRITE, MAC, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          in_prev_q;
  logic          ovr_q, ovr_d;
  logic          strobe_edge;

  logic          we_q, we_d;
  logic          zf_q, zf_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AW-1:0] coef_q, coef_d;
  logic          acc_clr_q, acc_clr_d;
  logic          acc_en_q, acc_en_d;
  logic          out_load_q, out_load_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  // (w - k) mod N without ever forming an out-of-range address.
  function automatic logic [AW-1:0] sub_mod(input logic [AW-1:0] w,
                                            input logic [CW-1:0] k);
    logic [XW-1:0] ww, kk, r;
    ww = XW'(w);
    kk = XW'(k);
    if (ww >= kk) r = ww - kk;
    else          r = ww + XW'(N) - kk;
    return r[AW-1:0];
  endfunction

  assign strobe_edge = bus.input_ready & ~in_prev_q;

  // Outputs are decoded from the transition so that, once registered, they
  // describe the state being entered. In INIT, k_q is the next address to
  // clear; k_q == N means the fill has completed.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    wptr_d     = wptr_q;
    we_d       = 1'b0;
    zf_d       = 1'b0;
    waddr_d    = '0;
    raddr_d    = '0;
    coef_d     = '0;
    acc_clr_d  = 1'b0;
    acc_en_d   = 1'b0;
    out_load_d = 1'b0;
    ready_d    = 1'b0;
    case (state_q)
      INIT: begin
        if (k_q == K_FILL) begin
          state_d = IDLE;
          k_d     = '0;
        end else begin
          we_d    = 1'b1;
          zf_d    = 1'b1;
          waddr_d = k_q[AW-1:0];
          k_d     = k_q + CW'(1);
        end
      end
      IDLE: begin
        if (strobe_edge) begin
          state_d   = WRITE;
          we_d      = 1'b1;
          waddr_d   = wptr_q;
          acc_clr_d = 1'b1;
        end
      end
      WRITE: begin
        state_d  = MAC;
        k_d      = '0;
        acc_en_d = 1'b1;
        coef_d   = '0;
        raddr_d  = wptr_q;
      end
      MAC: begin
        if (k_q == K_LAST) begin
          state_d    = DONE;
          k_d        = '0;
          out_load_d = 1'b1;
          ready_d    = 1'b1;
        end else begin
          k_d      = k_q + CW'(1);
          acc_en_d = 1'b1;
          coef_d   = k_d[AW-1:0];
          raddr_d  = sub_mod(wptr_q, k_d);
        end
      end
      DONE: begin
        state_d = IDLE;
        wptr_d  = (wptr_q == W_LAST) ? '0 : wptr_q + AW'(1);
      end
      default: begin
        state_d = INIT;
        k_d     = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
    // A dropped strobe beats a simultaneous clear.
    if (strobe_edge && (state_q != IDLE)) ovr_d = 1'b1;
    else if (bus.clr_ovr)                 ovr_d = 1'b0;
    else                                  ovr_d = ovr_q;
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      state_q    <= INIT;
      k_q        <= '0;
      wptr_q     <= '0;
      in_prev_q  <= 1'b0;
      ovr_q      <= 1'b0;
      we_q       <= 1'b0;
      zf_q       <= 1'b0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      coef_q     <= '0;
      acc_clr_q  <= 1'b0;
      acc_en_q   <= 1'b0;
      out_load_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      wptr_q     <= wptr_d;
      in_prev_q  <= bus.input_ready;
      ovr_q      <= ovr_d;
      we_q       <= we_d;
      zf_q       <= zf_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      coef_q     <= coef_d;
      acc_clr_q  <= acc_clr_d;
      acc_en_q   <= acc_en_d;
      out_load_q <= out_load_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.sample_we    = we_q;
  assign bus.zero_fill    = zf_q;
  assign bus.sample_waddr = waddr_q;
  assign bus.sample_raddr = raddr_q;
  assign bus.coef_addr    = coef_q;
  assign bus.acc_clr      = acc_clr_q;
  assign bus.acc_en       = acc_en_q;
  assign bus.out_load     = out_load_q;
  assign bus.output_ready = ready_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = ovr_q;
endmodule
